exp_range_ctrl: RTL
===================

Name: exp_range_ctrl

Overview:
- Range-reduction and rescale controller wrapped around the 5-cycle exp Taylor kernel (`computing_kernel_npp`).
- Front end: accepts x in [0,1) (8-bit fraction) on a valid/ready handshake, computes |t| and its sign, and launches one kernel operation.
- Back end: captures the kernel result {2,8}, multiplies it by e when x >= 0.75, and presents e^x on a valid/ready output.
- One operation in flight at a time.

Parameters:
- THRESH, 8'd192, range-reduction threshold (0.75 in 0.8 fixed point).
- E_CONST, 10'd696, e in {2,8} fixed point (2.71875).
- WAIT_MAX, 15, maximum WAIT-state cycles before a kernel timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  controller can accept a sample
- in_x  in  8  x, 0.8 unsigned fraction
- k_data  out  8  |t| to kernel iData
- k_sign  out  1  t negative, to kernel iSign
- k_valid  out  1  one-cycle launch pulse, to kernel iDataValid
- k_result  in  10  kernel oData, {2,8}
- k_result_valid  in  1  kernel oDataValid; level, stays high until the next launch
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_y  out  10  e^x, {2,8}
- err  out  1  sticky kernel-timeout flag

Behaviour:
- Reset values:
  - state = IDLE
  - in_ready = 1 (combinational, high only in IDLE)
  - k_valid = 0, k_data = 0, k_sign = 0
  - out_valid = 0, out_y = 0, err = 0
- All outputs except in_ready are registered.
- FSM states: IDLE, ISSUE, WAIT, SCALE, OUT.
- IDLE:
  - On in_valid & in_ready, register x.
  - If x < THRESH: t = x, sign = 0, scale = 0.
  - Else: t = 256 - x (8 bits, max 64), sign = 1, scale = 1.
  - Go to ISSUE.
- ISSUE:
  - k_valid = 1 for exactly this cycle; k_data/k_sign hold t and sign.
  - Always go to WAIT next cycle.
  - k_result_valid is ignored here because it may still be high from the previous operation.
- WAIT:
  - Wait counter starts at 0 and increments each cycle.
  - On k_result_valid: capture k_result into res and go to SCALE.
  - If the counter reaches WAIT_MAX without a result: res = 0, err set (sticky until reset), skip scaling, go to OUT.
- SCALE:
  - If scale: y = (res * E_CONST) >> 8, using a 20-bit product truncated toward zero, saturated to 10'h3FF if the value exceeds 1023.
  - Else: y = res.
  - Register y into out_y and go to OUT.
- OUT:
  - out_valid = 1; out_y held stable until out_valid & out_ready.
  - On that handshake: out_valid drops next cycle, go to IDLE.
  - in_ready stays low throughout.
- Latency (5-cycle kernel, out_ready = 1):
  - Accept edge E.
  - k_valid during cycle E+1.
  - k_result_valid from cycle E+6.
  - out_valid from cycle E+8.
  - Throughput: one sample per 9 cycles.
- in_valid is ignored outside IDLE. in_x is sampled only on the accept edge.
- Asynchronous reset mid-operation returns to IDLE with all reset values. It clears err. No partial result is emitted.

Decomposition:
- Package exp_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, SCALE, OUT)
  - fixed-point width constants (FRAC_W = 8, OUT_W = 10)
  - default THRESH and E_CONST
- Sub-module exp_scale: combinational multiply / shift / saturate. Inputs res[9:0] and scale; output y[9:0]. Unit-tested on its own.

Test Plan:
- x = 0, kernel model returns 256 -> k_data = 0, k_sign = 0; out_y = 256; out_valid 8 cycles after accept.
- x = 128, model returns 422 -> k_data = 128, k_sign = 0; out_y = 422 (no scaling).
- x = 192, model returns 199 -> k_data = 64, k_sign = 1; out_y = (199 * 696) >> 8 = 541.
- x = 255, model returns 255 -> k_data = 1, k_sign = 1; out_y = 693.
- out_ready held low for 3 cycles in OUT -> out_y and out_valid stable; in_ready = 0; a new in_valid is not accepted until the handshake completes.
- Kernel never responds -> after 15 WAIT cycles: out_y = 0, err = 1, err stays high across later samples. Separately, reset asserted in WAIT -> IDLE, err = 0, out_valid = 0, no output emitted.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared types and fixed-point constants for the exp range-reduction controller.
package exp_pkg;

  localparam int unsigned FRAC_W = 8;
  localparam int unsigned OUT_W  = 10;
  localparam int unsigned PROD_W = 20;

  localparam logic [FRAC_W-1:0] THRESH_DEF  = 8'd192;
  localparam logic [OUT_W-1:0]  E_CONST_DEF = 10'd696;
  localparam logic [OUT_W-1:0]  OUT_MAX     = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SCALE = 3'd3,
    OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/exp_scale.sv
// Rescale a {2,8} kernel result by e when range reduction was applied; saturates to 10 bits.
module exp_scale
  import exp_pkg::*;
#(
  parameter logic [OUT_W-1:0] E_CONST = E_CONST_DEF
) (
  input  logic [OUT_W-1:0] res_i,
  input  logic             scale_i,
  output logic [OUT_W-1:0] y_c
);

  localparam int unsigned SHIFT_W = PROD_W - FRAC_W;

  logic [PROD_W-1:0]  prod;
  logic [SHIFT_W-1:0] shifted;

  always_comb begin
    prod    = PROD_W'(res_i) * PROD_W'(E_CONST);
    shifted = prod[PROD_W-1:FRAC_W];
    y_c     = res_i;
    if (scale_i) begin
      y_c = (shifted > SHIFT_W'(OUT_MAX)) ? OUT_MAX : shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/exp_range_ctrl.sv
// Range-reduction front end and e-rescale back end around the 5-cycle exp Taylor kernel.
module exp_range_ctrl
  import exp_pkg::*;
#(
  parameter logic [FRAC_W-1:0] THRESH   = THRESH_DEF,
  parameter logic [OUT_W-1:0]  E_CONST  = E_CONST_DEF,
  parameter int unsigned       WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W-1:0] in_x,
  output logic [FRAC_W-1:0] k_data,
  output logic              k_sign,
  output logic              k_valid,
  input  logic [OUT_W-1:0]  k_result,
  input  logic              k_result_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_y,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  state_e            state_q, state_d;
  logic [FRAC_W-1:0] k_data_q, k_data_d;
  logic              k_sign_q, k_sign_d;
  logic              k_valid_q, k_valid_d;
  logic              scale_q, scale_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  res_q, res_d;
  logic [OUT_W-1:0]  out_y_q, out_y_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic [OUT_W-1:0]  scaled_c;

  exp_scale #(
    .E_CONST (E_CONST)
  ) u_scale (
    .res_i   (res_q),
    .scale_i (scale_q),
    .y_c     (scaled_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_data_q    <= '0;
      k_sign_q    <= 1'b0;
      k_valid_q   <= 1'b0;
      scale_q     <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_data_q    <= k_data_d;
      k_sign_q    <= k_sign_d;
      k_valid_q   <= k_valid_d;
      scale_q     <= scale_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_data_d = k_data_q;
    k_sign_d = k_sign_q;
    scale_d  = scale_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    out_y_d  = out_y_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Above the threshold, evaluate e^(x-1) and rescale by e afterwards.
          if (in_x < THRESH) begin
            k_data_d = in_x;
            k_sign_d = 1'b0;
            scale_d  = 1'b0;
          end else begin
            k_data_d = ~in_x + FRAC_W'(1);
            k_sign_d = 1'b1;
            scale_d  = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (k_result_valid) begin
          res_d   = k_result;
          state_d = SCALE;
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          res_d   = '0;
          out_y_d = '0;
          err_d   = 1'b1;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SCALE: begin
        out_y_d = scaled_c;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered off the next state so they align with ISSUE/OUT.
    k_valid_d   = (state_d == ISSUE);
    out_valid_d = (state_d == OUT);
  end

  assign in_ready  = (state_q == IDLE);
  assign k_data    = k_data_q;
  assign k_sign    = k_sign_q;
  assign k_valid   = k_valid_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign err       = err_q;

endmodule
